alu_chain_seq: RTL

//   Multi-cycle controller computing the 4-stage ALU chain with ONE shared ALU instead of four cascaded ones.

---
 rtl/alu_chain_seq.sv | 120 ++++++++++++
 1 files changed

// File: rtl/alu_chain_seq.sv
// rtl/alu_chain_seq.sv - four-step ALU chain sequenced over one shared external ALU
module alu_chain_seq #(
    parameter int WIDTH  = 32,
    parameter int OPW    = 5,
    parameter int OP_MAX = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OPW-1:0]   OP,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT,
    output logic             ERR,
    output logic             BUSY,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic [OPW-1:0]   ALU_OP,
    input  logic [WIDTH-1:0] ALU_OUT
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        S3   = 3'd3,
        S4   = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic [OPW-1:0] OP_LIMIT = OPW'(OP_MAX);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [OPW-1:0]   op_r;
    logic [WIDTH-1:0] t1;
    logic [WIDTH-1:0] t2;
    logic [WIDTH-1:0] t3;
    logic [WIDTH-1:0] out_r;
    logic             err_r;
    logic             op_bad;

    assign op_bad = (OP > OP_LIMIT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (IN_VALID) state_d = op_bad ? DONE : S1;
            S1:   state_d = S2;
            S2:   state_d = S3;
            S3:   state_d = S4;
            S4:   state_d = DONE;
            DONE: if (OUT_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand routing to the shared ALU; quiet (all zero) outside S1..S4.
    always_comb begin
        ALU_A  = '0;
        ALU_B  = '0;
        ALU_OP = '0;
        case (state_q)
            S1: begin ALU_A = a_r; ALU_B = b_r; ALU_OP = op_r; end
            S2: begin ALU_A = t1;  ALU_B = b_r; ALU_OP = op_r; end
            S3: begin ALU_A = t1;  ALU_B = t2;  ALU_OP = op_r; end
            S4: begin ALU_A = t3;  ALU_B = t2;  ALU_OP = op_r; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            op_r    <= '0;
            t1      <= '0;
            t2      <= '0;
            t3      <= '0;
            out_r   <= '0;
            err_r   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (IN_VALID) begin
                        a_r  <= A;
                        b_r  <= B;
                        op_r <= OP;
                        if (op_bad) begin
                            out_r <= '0;
                            err_r <= 1'b1;
                        end
                    end
                end
                S1: t1 <= ALU_OUT;
                S2: t2 <= ALU_OUT;
                S3: t3 <= ALU_OUT;
                S4: begin
                    out_r <= ALU_OUT;
                    err_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign BUSY      = (state_q != IDLE);
    assign OUT_VALID = (state_q == DONE);
    assign OUT       = out_r;
    assign ERR       = err_r;

endmodule
